hex_core: RTL and testbench
===========================

HEX_CORE -- requirements
Module: hex_core

Interface
REQ-001 Parameter WIDTH, default 8, data/address/register width in bits; legal values are multiples of 4 that are at least 8.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_req  output  1  memory transaction request.
REQ-005 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-006 mem_addr  output  WIDTH  word address; valid while mem_req=1.
REQ-007 mem_wdata  output  WIDTH  write data; valid while mem_req=1 and mem_we=1.
REQ-008 mem_rdata  input  WIDTH  read data; sampled in the cycle mem_ready=1.
REQ-009 mem_ready  input  1  transaction completes in any cycle with mem_req=1 and mem_ready=1.
REQ-010 halted  output  1  core stopped by the halt instruction.
REQ-011 retire  output  1  one-cycle pulse when an instruction completes.

Function
REQ-012 Architectural state: registers A, B, PC and operand O, each WIDTH bits; prefix register P, WIDTH-4 bits; instruction register I, 4 bits.
REQ-013 FSM states: FETCH, EXEC, MEM, HALT.
REQ-014 FETCH behaviour:
- Drives mem_req=1, mem_we=0, mem_addr=PC.
- On mem_ready: I<=mem_rdata[7:4]; O<={P, mem_rdata[3:0]}; PC<=PC+1; next state EXEC.
- mem_rdata bits above 7 are ignored.
REQ-015 EXEC, single-cycle opcodes; each asserts retire and returns to FETCH (BR with O all-ones excepted, see REQ-018):
- 3 LDAC: A<=O.
- 4 LDBC: B<=O.
- 5 LDAP: A<=PC+O.
- 9 BR: PC<=PC+O.
- 10 BRZ: PC<=PC+O if A==0.
- 11 BRN: PC<=PC+O if A[WIDTH-1]==1.
- 12 BRB: PC<=B.
- 13 ADD: A<=A+B.
- 14 SUB: A<=A-B.
- 15 PFIX: see REQ-017.
REQ-016 EXEC, memory opcodes; each goes to MEM, which holds the request until mem_ready, then completes the write-back, asserts retire and returns to FETCH:
- 0 LDAM: A<=mem[O].
- 1 LDBM: B<=mem[O].
- 2 STAM: mem[O]<=A.
- 6 LDAI: A<=mem[A+O].
- 7 LDBI: B<=mem[B+O].
- 8 STAI: mem[B+O]<=A.
REQ-017 P update on leaving EXEC: P<=O[WIDTH-5:0] when I=PFIX, otherwise P<=0; k consecutive PFIX instructions therefore build an operand of 4(k+1) bits, and upper bits shifted out of P are discarded.
REQ-018 BR with O all-ones (branch-to-self): PC is not updated, state goes to HALT, halted=1 and retire pulses once; HALT is left only by reset.
REQ-019 All arithmetic and address computation is unsigned modulo 2^WIDTH; PC wraps from all-ones to 0.
REQ-020 Handshake:
- mem_addr, mem_we and mem_wdata stay stable from mem_req rise until the completing cycle.
- mem_req deasserts in the cycle after completion unless the next state issues a new request; back-to-back requests are permitted.
REQ-021 Latency with zero wait states: 2 cycles per non-memory instruction and 3 cycles per memory instruction; each wait state adds one cycle.
REQ-022 The effective address is computed from register values at EXEC entry.
REQ-023 A, B and PC update only as listed above.
REQ-024 mem_ready while mem_req=0 is ignored.

Reset
REQ-025 While reset=1: A, B, PC, O, P and I are 0, state is FETCH, and mem_req, halted and retire are 0.
REQ-026 The first fetch request (address 0) is issued in the first cycle after reset deasserts.
REQ-027 Reset asserted during an outstanding transaction abandons it: mem_req=0 in the following cycle, and no register or memory write occurs from the abandoned transaction.
REQ-028 Reset takes priority over all other events, including a coincident mem_ready.

Verification
REQ-029 WIDTH=8, zero-wait memory, program 0x35,0x43,0xD0 (LDAC 5, LDBC 3, ADD) -> A=0x08, B=0x03; retire pulses at cycles 2, 4, 6.
REQ-030 WIDTH=16, program 0xF1,0xF2,0x33 -> A=0x0123; P=0 after the LDAC.
REQ-031 WIDTH=8, memory holds 0x00 at address 0x20; mem_ready delayed 3 cycles on the LDAM 0x20 data read; then BRZ jumps -> LDAM takes 6 cycles; mem_addr=0x20 is held stable throughout; the branch is taken.
REQ-032 WIDTH=8, A=0x80, then BRN +2 -> PC advances by 3 from the BRN address; A=0x7F, BRN +2 -> not taken.
REQ-033 WIDTH=8, program 0x9F at address 0x10 -> halted=1, PC=0x11, no further mem_req; a 1-cycle reset pulse -> fetch resumes at address 0.
REQ-034 Reset asserted in the second wait cycle of a STAI to address 0x40 -> no write completes; mem_req=0 in the next cycle; all registers are 0.

Source files
------------

// File: rtl/hex_core_if.sv
// hex_core_if -- memory bus between the hex_core processor and its memory.
//
// Parameters
//   WIDTH      data/address width in bits
// Signals
//   mem_req    transaction request (master -> slave)
//   mem_we     1 = write, 0 = read; valid while mem_req=1
//   mem_addr   word address; valid while mem_req=1
//   mem_wdata  write data; valid while mem_req=1 and mem_we=1
//   mem_rdata  read data, sampled in the completing cycle (slave -> master)
//   mem_ready  completes the transaction in any cycle with mem_req=1
// Modports
//   master     the core side
//   slave      the memory side
interface hex_core_if #(
  parameter int WIDTH = 8
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/hex_core.sv
// hex_core -- small accumulator processor with 4-bit opcodes, a 4-bit
// immediate and a prefix register that widens the immediate 4 bits per
// PFIX instruction.
//
// Parameters
//   WIDTH    register/data/address width; multiple of 4, at least 8
// Ports
//   clk      sole clock, rising edge
//   reset    synchronous, active-high reset
//   bus      memory bus (hex_core_if master modport)
//   halted   core stopped by the branch-to-self instruction
//   retire   one-cycle pulse when an instruction completes
module hex_core #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  hex_core_if.master bus,
  output logic       halted,
  output logic       retire
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  typedef enum logic [3:0] {
    OP_LDAM = 4'd0,  OP_LDBM = 4'd1,  OP_STAM = 4'd2,  OP_LDAC = 4'd3,
    OP_LDBC = 4'd4,  OP_LDAP = 4'd5,  OP_LDAI = 4'd6,  OP_LDBI = 4'd7,
    OP_STAI = 4'd8,  OP_BR   = 4'd9,  OP_BRZ  = 4'd10, OP_BRN  = 4'd11,
    OP_BRB  = 4'd12, OP_ADD  = 4'd13, OP_SUB  = 4'd14, OP_PFIX = 4'd15
  } opcode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  opcode_e          ir_q;
  logic [WIDTH-1:0] a_q, b_q, pc_q, o_q;
  logic [WIDTH-5:0] p_q;
  // Effective address latched on leaving EXEC so mem_addr holds steady
  // through any number of wait states.
  logic [WIDTH-1:0] ea_q, ea_c;

  logic is_mem_op, is_store, halt_br;
  logic req_c, we_c, retire_c;
  logic [WIDTH-1:0] addr_c;

  // Opcode decode; ir_q is stable from EXEC through MEM.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    is_mem_op = 1'b0;
    is_store  = 1'b0;
    ea_c      = o_q;
    case (ir_q)
      OP_LDAM, OP_LDBM: is_mem_op = 1'b1;
      OP_STAM: begin
        is_mem_op = 1'b1;
        is_store  = 1'b1;
      end
      OP_LDAI: begin
        is_mem_op = 1'b1;
        ea_c      = a_q + o_q;
      end
      OP_LDBI: begin
        is_mem_op = 1'b1;
        ea_c      = b_q + o_q;
      end
      OP_STAI: begin
        is_mem_op = 1'b1;
        is_store  = 1'b1;
        ea_c      = b_q + o_q;
      end
      default: ;
    endcase
  end

  // BR with an all-ones offset targets its own address (PC was already
  // incremented past it), which is the halt idiom.
  assign halt_br = (ir_q == OP_BR) && (&o_q);

  // Next state and bus/retire outputs.
  always_comb begin
    state_d  = state_q;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = pc_q;
    retire_c = 1'b0;
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (bus.mem_ready) state_d = EXEC;
      end
      EXEC: begin
        if (is_mem_op) begin
          state_d = MEM;
        end else begin
          retire_c = 1'b1;
          state_d  = halt_br ? HALT : FETCH;
        end
      end
      MEM: begin
        req_c  = 1'b1;
        we_c   = is_store;
        addr_c = ea_q;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_d  = FETCH;
        end
      end
      default: ;
    endcase
  end

  // Gating with reset keeps the bus idle while reset is held, so an
  // abandoned transaction cannot complete in the reset cycle.
  assign bus.mem_req   = req_c & ~reset;
  assign bus.mem_we    = we_c;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = a_q;
  assign retire        = retire_c & ~reset;
  assign halted        = (state_q == HALT) & ~reset;

  // NOTE: architectural state is updated with non-blocking assignments so
  // every register samples pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q    <= OP_LDAM;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      o_q     <= '0;
      p_q     <= '0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: begin
          if (bus.mem_ready) begin
            ir_q <= opcode_e'(bus.mem_rdata[7:4]);
            o_q  <= {p_q, bus.mem_rdata[3:0]};
            pc_q <= pc_q + ONE;
          end
        end
        EXEC: begin
          p_q  <= (ir_q == OP_PFIX) ? o_q[WIDTH-5:0] : '0;
          ea_q <= ea_c;
          case (ir_q)
            OP_LDAC: a_q <= o_q;
            OP_LDBC: b_q <= o_q;
            OP_LDAP: a_q <= pc_q + o_q;
            OP_BR:   if (!halt_br) pc_q <= pc_q + o_q;
            OP_BRZ:  if (a_q == '0) pc_q <= pc_q + o_q;
            OP_BRN:  if (a_q[WIDTH-1]) pc_q <= pc_q + o_q;
            OP_BRB:  pc_q <= b_q;
            OP_ADD:  a_q <= a_q + b_q;
            OP_SUB:  a_q <= a_q - b_q;
            default: ;
          endcase
        end
        MEM: begin
          if (bus.mem_ready) begin
            case (ir_q)
              OP_LDAM, OP_LDAI: a_q <= bus.mem_rdata;
              OP_LDBM, OP_LDBI: b_q <= bus.mem_rdata;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_core.sv
// tb_hex_core -- directed-vector bench for hex_core. An 8-bit core with a
// wait-state-capable memory and a 16-bit core with a zero-wait memory run
// short hand-assembled programs; expected values are worked out by hand.
module tb_hex_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset8  = 1'b1;
  logic reset16 = 1'b1;
  logic halted8, retire8, halted16, retire16;

  hex_core_if #(.WIDTH(8))  bus8 ();
  hex_core_if #(.WIDTH(16)) bus16 ();

  hex_core #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .reset  (reset8),
    .bus    (bus8.master),
    .halted (halted8),
    .retire (retire8)
  );

  hex_core #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .reset  (reset16),
    .bus    (bus16.master),
    .halted (halted16),
    .retire (retire16)
  );

  // 8-bit memory: reads come from mem8, writes are logged, and accesses to
  // slow_addr are stretched by slow_waits wait states.
  logic [7:0] mem8 [256];
  logic [7:0] slow_addr  = 8'hFF;
  int         slow_waits = 0;
  int         wcnt8 = 0;
  int         need8;
  int         wr_count = 0;
  logic [7:0] last_waddr = 8'h00;
  logic [7:0] last_wdata = 8'h00;

  always_comb need8 = (bus8.mem_addr == slow_addr) ? slow_waits : 0;
  assign bus8.mem_rdata = mem8[bus8.mem_addr];
  assign bus8.mem_ready = bus8.mem_req && (wcnt8 >= need8);

  always @(posedge clk) begin
    if (reset8 || !bus8.mem_req) begin
      wcnt8 <= 0;
    end else if (bus8.mem_ready) begin
      wcnt8 <= 0;
      if (bus8.mem_we) begin
        wr_count   <= wr_count + 1;
        last_waddr <= bus8.mem_addr;
        last_wdata <= bus8.mem_wdata;
      end
    end else begin
      wcnt8 <= wcnt8 + 1;
    end
  end

  // 16-bit memory: zero wait states, read-only program store.
  logic [15:0] mem16 [256];
  assign bus16.mem_rdata = mem16[bus16.mem_addr[7:0]];
  assign bus16.mem_ready = bus16.mem_req;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear8();
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
    slow_addr  = 8'hFF;
    slow_waits = 0;
  endtask

  // Hold reset8 for two edges and return at a negedge with reset still high.
  task automatic start8();
    reset8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Release just after an edge: the following interval is cycle 1.
  task automatic release8();
    @(posedge clk);
    #1 reset8 = 1'b0;
    cyc = 0;
  endtask

  // Advance to the negedge inside cycle n.
  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [11:0] mask;
  int held, cnt_a, cnt_b, w0, rcount;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- LDAC 5, LDBC 3, ADD: reset state, retire timing, result ----
    clear8();
    mem8[0] = 8'h35; mem8[1] = 8'h43; mem8[2] = 8'hD0;
    start8();
    check("rst_req",    bus8.mem_req, 0);
    check("rst_halted", halted8, 0);
    check("rst_retire", retire8, 0);
    check("rst_a",      dut8.a_q, 0);
    check("rst_pc",     dut8.pc_q, 0);
    release8();
    mask = '0;
    for (int c = 1; c <= 6; c++) begin
      to_cycle(c);
      if (c == 1) begin
        check("first_fetch_req",  bus8.mem_req, 1);
        check("first_fetch_addr", bus8.mem_addr, 8'h00);
      end
      mask[c-1] = retire8;
    end
    check("add_retire_cycles", mask, 12'h02A);
    to_cycle(7);
    check("add_a", dut8.a_q, 8'h08);
    check("add_b", dut8.b_q, 8'h03);

    // ---- LDAC 7, LDAM 0x20 with 3 waits, BRZ +5 taken ----
    clear8();
    mem8[0] = 8'h37; mem8[1] = 8'hF2; mem8[2] = 8'h00; mem8[3] = 8'hA5;
    slow_addr = 8'h20; slow_waits = 3;
    start8();
    release8();
    mask = '0;
    held = 0;
    for (int c = 1; c <= 12; c++) begin
      to_cycle(c);
      mask[c-1] = retire8;
      if (c >= 7 && c <= 10)
        held += int'(bus8.mem_req && !bus8.mem_we && bus8.mem_addr == 8'h20);
    end
    check("ldam_wait_retires", mask, 12'hA0A);
    check("ldam_addr_held",    held, 4);
    to_cycle(13);
    check("brz_target_addr", bus8.mem_addr, 8'h09);
    check("brz_target_req",  bus8.mem_req, 1);
    check("ldam_a_zero",     dut8.a_q, 8'h00);

    // ---- BRN taken on A=0x80, not taken on A=0x7F ----
    clear8();
    mem8[0] = 8'hF8; mem8[1] = 8'h30; mem8[2] = 8'hB2;
    mem8[5] = 8'hF7; mem8[6] = 8'h3F; mem8[7] = 8'hB2;
    start8();
    release8();
    to_cycle(5);
    check("brn_a_neg", dut8.a_q, 8'h80);
    to_cycle(7);
    check("brn_taken_addr", bus8.mem_addr, 8'h05);
    to_cycle(13);
    check("brn_not_taken_addr", bus8.mem_addr, 8'h08);
    check("brn_a_pos", dut8.a_q, 8'h7F);

    // ---- halt via PFIX F / BR F at 0x10, then reset resumes at 0 ----
    clear8();
    mem8[0] = 8'h9E; mem8[8'h0F] = 8'hFF; mem8[8'h10] = 8'h9F;
    start8();
    release8();
    to_cycle(6);
    check("halt_retire", retire8, 1);
    to_cycle(7);
    check("halt_flag", halted8, 1);
    check("halt_pc",   dut8.pc_q, 8'h11);
    check("halt_req",  bus8.mem_req, 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 8; c <= 20; c++) begin
      to_cycle(c);
      cnt_a += int'(bus8.mem_req) + int'(retire8);
      cnt_b += int'(halted8);
    end
    check("halt_quiet",  cnt_a, 0);
    check("halt_sticky", cnt_b, 13);
    @(posedge clk);
    #1 reset8 = 1'b1;
    @(posedge clk);
    #1 reset8 = 1'b0;
    @(negedge clk);
    check("resume_req",    bus8.mem_req, 1);
    check("resume_addr",   bus8.mem_addr, 8'h00);
    check("resume_halted", halted8, 0);

    // ---- STAI to 0x40 abandoned by reset in the second wait cycle ----
    foreach (mask[k]) mask[k] = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      clear8();
      mem8[0] = 8'hF4; mem8[1] = 8'h40; mem8[2] = 8'h35; mem8[3] = 8'h80;
      slow_addr  = 8'h40;
      slow_waits = (pass == 0) ? 3 : 1;
      start8();
      release8();
      w0 = wr_count;
      to_cycle(10);
      check("stai_req",   bus8.mem_req, 1);
      check("stai_we",    bus8.mem_we, 1);
      check("stai_addr",  bus8.mem_addr, 8'h40);
      check("stai_wdata", bus8.mem_wdata, 8'h05);
      reset8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_req",   bus8.mem_req, 0);
      check("abort_write", wr_count - w0, 0);
      check("abort_regs",
            {dut8.a_q, dut8.b_q, dut8.pc_q, dut8.o_q, dut8.p_q, 4'(dut8.ir_q)}, 0);
    end

    // ---- mixed program: SUB, STAM, LDBI, BRB, LDAP, halt ----
    clear8();
    mem8[0] = 8'h39; mem8[1] = 8'h44; mem8[2] = 8'hE0; mem8[3] = 8'hF3;
    mem8[4] = 8'h20; mem8[5] = 8'h72; mem8[6] = 8'hC0;
    mem8[8'hC0] = 8'h51; mem8[8'hC1] = 8'hFF; mem8[8'hC2] = 8'h9F;
    start8();
    release8();
    w0 = wr_count;
    rcount = 0;
    while (!halted8 && cyc < 60) begin
      to_cycle(cyc + 1);
      rcount += int'(retire8);
    end
    check("mix_halt_cycle", cyc, 23);
    check("mix_retires",    rcount, 10);
    check("mix_writes",     wr_count - w0, 1);
    check("mix_waddr",      last_waddr, 8'h30);
    check("mix_wdata",      last_wdata, 8'h05);
    check("mix_a",          dut8.a_q, 8'hC2);
    check("mix_b",          dut8.b_q, 8'hC0);
    check("mix_pc",         dut8.pc_q, 8'hC3);

    // ---- WIDTH=16: PFIX 1, PFIX 2, LDAC 3 -> 0x0123; high rdata ignored ----
    for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
    mem16[0] = 16'hAAF1; mem16[1] = 16'h55F2; mem16[2] = 16'hFF33;
    reset16 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("w16_rst_a", dut16.a_q, 0);
    @(posedge clk);
    #1 reset16 = 1'b0;
    cyc = 0;
    to_cycle(5);
    check("w16_prefix_p", dut16.p_q, 12'h012);
    to_cycle(7);
    check("w16_a", dut16.a_q, 16'h0123);
    check("w16_p_cleared", dut16.p_q, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
